// File: rtl/rgb_to_yuv_csc_if.sv
// Pixel-in / YUV422-out bus of the colour-space converter.
interface rgb_to_yuv_csc_if #(
    parameter int unsigned PIXEL_WIDTH   = 16,
    parameter int unsigned PIXEL_PER_CLK = 8,
    parameter int unsigned OUT_WIDTH     = 8
);
    logic [PIXEL_WIDTH*PIXEL_PER_CLK*3-1:0] rgb_i;
    logic                                   rgb_valid_i;
    logic                                   line_valid_i;
    logic                                   matrix_sel_i;
    logic                                   range_sel_i;
    logic                                   pack_sel_i;
    logic [PIXEL_PER_CLK*2*OUT_WIDTH-1:0]   yuv_o;
    logic                                   yuv_valid_o;
    logic                                   yuv_line_o;

    modport master (
        output rgb_i, rgb_valid_i, line_valid_i, matrix_sel_i, range_sel_i, pack_sel_i,
        input  yuv_o, yuv_valid_o, yuv_line_o
    );

    modport slave (
        input  rgb_i, rgb_valid_i, line_valid_i, matrix_sel_i, range_sel_i, pack_sel_i,
        output yuv_o, yuv_valid_o, yuv_line_o
    );
endinterface

// File: rtl/rgb_to_yuv_csc.sv
// RGB to YUV422 converter: BT.601/BT.709, full/limited range, rounding,
// clamping, pair-averaged chroma, two lane orders, fixed 5-cycle latency.
module rgb_to_yuv_csc #(
    parameter int unsigned PIXEL_WIDTH   = 16,
    parameter int unsigned PIXEL_PER_CLK = 8,
    parameter int unsigned OUT_WIDTH     = 8
) (
    input  logic              clk_i,
    input  logic              reset_i,
    rgb_to_yuv_csc_if.slave   bus
);
    localparam int unsigned PW  = PIXEL_WIDTH;
    localparam int unsigned N   = PIXEL_PER_CLK;
    localparam int unsigned OW  = OUT_WIDTH;
    localparam int unsigned NP  = N / 2;
    localparam int unsigned AW  = PW + 10;
    localparam int unsigned S   = PW + 8 - OW;
    localparam int unsigned TW  = OW + 9;
    localparam int unsigned OW1 = OW + 1;

    localparam logic signed [AW-1:0] RND   = AW'(2**(S-1));
    localparam logic signed [AW-1:0] Y_MAX = AW'(2**OW - 1);
    localparam logic signed [AW-1:0] C_MAX = AW'(2**(OW-1) - 1);
    localparam logic signed [AW-1:0] C_MIN = -AW'(2**(OW-1));
    localparam logic [OW-1:0]        Y_OFS = OW'(2**(OW-4));
    localparam logic [OW-1:0]        C_OFS = OW'(2**(OW-1));

    // Coefficient k = row*3 + col, rows Y/U/V, columns R/G/B.
    function automatic logic signed [9:0] coef(input logic bt709, input int unsigned k);
        case (k)
            0:       return bt709 ?  10'sd54  :  10'sd77;
            1:       return bt709 ?  10'sd183 :  10'sd150;
            2:       return bt709 ?  10'sd19  :  10'sd29;
            3:       return bt709 ? -10'sd29  : -10'sd43;
            4:       return bt709 ? -10'sd98  : -10'sd84;
            5:       return 10'sd127;
            6:       return 10'sd127;
            7:       return bt709 ? -10'sd116 : -10'sd106;
            8:       return bt709 ? -10'sd11  : -10'sd21;
            default: return '0;
        endcase
    endfunction

    function automatic logic signed [AW-1:0] rshift(input logic signed [AW-1:0] a);
        return (a + RND) >>> S;
    endfunction

    function automatic logic [OW-1:0] clamp_y(input logic signed [AW-1:0] v);
        if (v[AW-1])    return '0;
        if (v > Y_MAX)  return '1;
        return v[OW-1:0];
    endfunction

    function automatic logic signed [OW-1:0] clamp_c(input logic signed [AW-1:0] v);
        if (v < C_MIN)  return {1'b1, {(OW-1){1'b0}}};
        if (v > C_MAX)  return {1'b0, {(OW-1){1'b1}}};
        return v[OW-1:0];
    endfunction

    function automatic logic [OW-1:0] lim_y(input logic [OW-1:0] y);
        logic [TW-1:0] t;
        t = TW'(y) * TW'(219) + TW'(128);
        return OW'(t >> 8) + Y_OFS;
    endfunction

    function automatic logic signed [OW-1:0] lim_c(input logic signed [OW-1:0] c);
        logic signed [TW-1:0] t;
        t = TW'(c) * TW'(224) + TW'(128);
        return OW'(t >>> 8);
    endfunction

    function automatic logic [OW-1:0] avg_c(input logic signed [OW-1:0] a,
                                            input logic signed [OW-1:0] b);
        logic signed [OW1-1:0] t;
        logic signed [OW-1:0]  h;
        t = OW1'(a) + OW1'(b) + OW1'(1);
        h = OW'(t >>> 1);
        return h + C_OFS;
    endfunction

    logic                   line_prev;
    logic                   matrix_q, range_q, pack_q;
    logic                   line_start, matrix_in, range_in, pack_in;
    logic [4:0]             vld;

    logic signed [AW-1:0]   s1_prod [N][9];
    logic                   s1_range, s1_pack;
    logic signed [AW-1:0]   s2_acc  [N][3];
    logic                   s2_range, s2_pack;
    logic [OW-1:0]          s3_y    [N];
    logic signed [OW-1:0]   s3_c    [N][2];
    logic                   s3_range, s3_pack;
    logic [OW-1:0]          s4_y    [N];
    logic signed [OW-1:0]   s4_c    [N][2];
    logic                   s4_pack;
    logic [N*2*OW-1:0]      pack_d, yuv_q;

    // A beat arriving with the line start already uses the new mode.
    assign line_start = bus.line_valid_i & ~line_prev;
    assign matrix_in  = line_start ? bus.matrix_sel_i : matrix_q;
    assign range_in   = line_start ? bus.range_sel_i  : range_q;
    assign pack_in    = line_start ? bus.pack_sel_i   : pack_q;

    // Mode latch on line start; line_prev resets high so a reset released
    // mid-line does not look like a line start and defaults stay in force.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            line_prev <= 1'b1;
            matrix_q  <= 1'b0;
            range_q   <= 1'b0;
            pack_q    <= 1'b0;
        end else begin
            line_prev <= bus.line_valid_i;
            if (line_start) begin
                matrix_q <= bus.matrix_sel_i;
                range_q  <= bus.range_sel_i;
                pack_q   <= bus.pack_sel_i;
            end
        end
    end

    // Valid shift register, one bit per pipeline stage.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) vld <= '0;
        else         vld <= {vld[3:0], bus.rgb_valid_i};
    end

    // S1: products; the mode bits travel with the beat from here on.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned p = 0; p < N; p++)
                for (int unsigned k = 0; k < 9; k++)
                    s1_prod[p][k] <= '0;
            s1_range <= 1'b0;
            s1_pack  <= 1'b0;
        end else if (bus.rgb_valid_i) begin
            for (int unsigned p = 0; p < N; p++)
                for (int unsigned k = 0; k < 9; k++)
                    s1_prod[p][k] <= $signed({{(AW-PW){1'b0}},
                                              bus.rgb_i[p*3*PW + (2 - k%3)*PW +: PW]})
                                     * AW'(coef(matrix_in, k));
            s1_range <= range_in;
            s1_pack  <= pack_in;
        end
    end

    // S2: per-pixel Y/U/V accumulations.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned p = 0; p < N; p++)
                for (int unsigned r = 0; r < 3; r++)
                    s2_acc[p][r] <= '0;
            s2_range <= 1'b0;
            s2_pack  <= 1'b0;
        end else if (vld[0]) begin
            for (int unsigned p = 0; p < N; p++)
                for (int unsigned r = 0; r < 3; r++)
                    s2_acc[p][r] <= s1_prod[p][3*r] + s1_prod[p][3*r+1] + s1_prod[p][3*r+2];
            s2_range <= s1_range;
            s2_pack  <= s1_pack;
        end
    end

    // S3: round, shift and clamp to output width.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned p = 0; p < N; p++) begin
                s3_y[p]    <= '0;
                s3_c[p][0] <= '0;
                s3_c[p][1] <= '0;
            end
            s3_range <= 1'b0;
            s3_pack  <= 1'b0;
        end else if (vld[1]) begin
            for (int unsigned p = 0; p < N; p++) begin
                s3_y[p]    <= clamp_y(rshift(s2_acc[p][0]));
                s3_c[p][0] <= clamp_c(rshift(s2_acc[p][1]));
                s3_c[p][1] <= clamp_c(rshift(s2_acc[p][2]));
            end
            s3_range <= s2_range;
            s3_pack  <= s2_pack;
        end
    end

    // S4: optional limited-range scaling (chroma still signed here).
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned p = 0; p < N; p++) begin
                s4_y[p]    <= '0;
                s4_c[p][0] <= '0;
                s4_c[p][1] <= '0;
            end
            s4_pack <= 1'b0;
        end else if (vld[2]) begin
            for (int unsigned p = 0; p < N; p++) begin
                s4_y[p]    <= s3_range ? lim_y(s3_y[p])    : s3_y[p];
                s4_c[p][0] <= s3_range ? lim_c(s3_c[p][0]) : s3_c[p][0];
                s4_c[p][1] <= s3_range ? lim_c(s3_c[p][1]) : s3_c[p][1];
            end
            s4_pack <= s3_pack;
        end
    end

    // S5 combinational part: chroma pair average, offset and lane packing.
    always_comb begin
        pack_d = '0;
        for (int unsigned k = 0; k < NP; k++) begin
            if (s4_pack)
                pack_d[k*4*OW +: 4*OW] = {avg_c(s4_c[2*k][1], s4_c[2*k+1][1]), s4_y[2*k+1],
                                          avg_c(s4_c[2*k][0], s4_c[2*k+1][0]), s4_y[2*k]};
            else
                pack_d[k*4*OW +: 4*OW] = {s4_y[2*k], avg_c(s4_c[2*k][0], s4_c[2*k+1][0]),
                                          s4_y[2*k+1], avg_c(s4_c[2*k][1], s4_c[2*k+1][1])};
        end
    end

    // S5 register: output holds between valid beats.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)     yuv_q <= '0;
        else if (vld[3]) yuv_q <= pack_d;
    end

    assign bus.yuv_o       = yuv_q;
    assign bus.yuv_valid_o = vld[4];
    // vld clears asynchronously, so in reset this reduces to line_valid_i.
    assign bus.yuv_line_o  = bus.line_valid_i | (|vld);

endmodule
